// File: rtl/pio_mbox_pkg.sv
// ============================================================================
// Module : pio_mbox_pkg
// Desc   : Shared command/state encodings and register bit positions for the
//          PIO mailbox responder.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package pio_mbox_pkg;

    typedef enum logic [1:0] {
        CMD_STATUS = 2'b00,
        CMD_PUSH   = 2'b01,
        CMD_POP    = 2'b10,
        CMD_FLUSH  = 2'b11
    } cmd_e;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_CAPTURE = 2'b01,
        ST_EXEC    = 2'b10,
        ST_DONE    = 2'b11
    } state_e;

    // cmd_ctrl layout
    localparam int c_ctrl_req_bit  = 0;
    localparam int c_ctrl_cmd_lsb  = 1;
    localparam int c_ctrl_cmd_msb  = 2;
    localparam int c_ctrl_cnt_lsb  = 3;
    localparam int c_ctrl_cnt_msb  = 6;
    localparam int c_ctrl_rsvd_bit = 7;

    // rsp_stat layout
    localparam int c_stat_ack_bit  = 0;
    localparam int c_stat_busy_bit = 1;
    localparam int c_stat_err_bit  = 2;
    localparam int c_stat_lvl_lsb  = 3;
    localparam int c_stat_lvl_msb  = 7;

    localparam logic [3:0] c_max_count = 4'd8;

endpackage : pio_mbox_pkg

`default_nettype wire

// File: rtl/mbox_byte_fifo.sv
// ============================================================================
// Module : mbox_byte_fifo
// Desc   : Single-clock byte FIFO with push, pop, flush, full/empty and level.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module mbox_byte_fifo #(
    parameter int DEPTH = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_push,
    input  logic [7:0] i_wdata,
    input  logic       i_pop,
    input  logic       i_flush,
    output logic [7:0] o_rdata,
    output logic       o_full,
    output logic       o_empty,
    output logic [4:0] o_level
);

    localparam int c_aw = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [7:0]      r_mem [DEPTH];
    logic [c_aw-1:0] r_wr_ptr;
    logic [c_aw-1:0] r_rd_ptr;
    logic [4:0]      r_level;
    logic            w_push_ok;
    logic            w_pop_ok;

    assign o_full    = (r_level == 5'(DEPTH));
    assign o_empty   = (r_level == 5'd0);
    assign o_level   = r_level;
    assign o_rdata   = r_mem[r_rd_ptr];
    assign w_push_ok = i_push & ~o_full  & ~i_flush;
    assign w_pop_ok  = i_pop  & ~o_empty & ~i_flush;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= 5'd0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= 5'd0;
        end else begin
            if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + 1'b1;
            r_level <= r_level + 5'(w_push_ok) - 5'(w_pop_ok);
        end
    end

    always_ff @(posedge clk) begin
        if (w_push_ok) r_mem[r_wr_ptr] <= i_wdata;
    end

endmodule : mbox_byte_fifo

`default_nettype wire

// File: rtl/pio_mailbox_responder.sv
// ============================================================================
// Module : pio_mailbox_responder
// Desc   : Toggle-handshake PIO mailbox servicing STATUS/PUSH/POP/FLUSH against
//          a byte FIFO. Define PIO_MBOX_STICKY_ERR_EN for a sticky error flag.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module pio_mailbox_responder #(
    parameter int DEPTH = 16
) (
    input  logic       clk_clk,
    input  logic       reset_reset,
    input  logic [7:0] cmd_ctrl,
    input  logic [7:0] cmd_data0,
    input  logic [7:0] cmd_data1,
    input  logic [7:0] cmd_data2,
    input  logic [7:0] cmd_data3,
    input  logic [7:0] cmd_data4,
    input  logic [7:0] cmd_data5,
    input  logic [7:0] cmd_data6,
    input  logic [7:0] cmd_data7,
    output logic [7:0] rsp_stat,
    output logic [7:0] rsp_data0,
    output logic [7:0] rsp_data1,
    output logic [7:0] rsp_data2,
    output logic [7:0] rsp_data3,
    output logic [7:0] rsp_data4,
    output logic [7:0] rsp_data5,
    output logic [7:0] rsp_data6,
    output logic [7:0] rsp_data7
);

    import pio_mbox_pkg::*;

    state_e     r_state;
    state_e     w_state_nxt;
    cmd_e       r_cmd;
    logic       r_last_req;
    logic       r_ack;
    logic       r_busy;
    logic       r_err;
    logic [3:0] r_count;
    logic [3:0] r_idx;
    logic [7:0] r_cmd_data [8];
    logic [7:0] r_rsp_data [8];
    logic [7:0] w_cmd_data [8];

    logic       w_req;
    logic [3:0] w_cnt_raw;
    logic [3:0] w_cnt_clamped;
    logic       w_detect;
    logic       w_push;
    logic       w_pop;
    logic       w_flush;
    logic       w_set_err;
    logic       w_push_fin;
    logic [7:0] w_fifo_rdata;
    logic       w_fifo_full;
    logic       w_fifo_empty;
    logic [4:0] w_fifo_level;
    logic       w_unused;

    assign w_cmd_data[0] = cmd_data0;
    assign w_cmd_data[1] = cmd_data1;
    assign w_cmd_data[2] = cmd_data2;
    assign w_cmd_data[3] = cmd_data3;
    assign w_cmd_data[4] = cmd_data4;
    assign w_cmd_data[5] = cmd_data5;
    assign w_cmd_data[6] = cmd_data6;
    assign w_cmd_data[7] = cmd_data7;

    assign w_req         = cmd_ctrl[c_ctrl_req_bit];
    assign w_cnt_raw     = cmd_ctrl[c_ctrl_cnt_msb:c_ctrl_cnt_lsb];
    assign w_cnt_clamped = (w_cnt_raw > c_max_count) ? c_max_count : w_cnt_raw;
    assign w_detect      = (r_state == ST_IDLE) && (w_req != r_last_req);
    assign w_unused      = cmd_ctrl[c_ctrl_rsvd_bit];

    mbox_byte_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk     (clk_clk),
        .rst     (reset_reset),
        .i_push  (w_push),
        .i_wdata (r_cmd_data[r_idx[2:0]]),
        .i_pop   (w_pop),
        .i_flush (w_flush),
        .o_rdata (w_fifo_rdata),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty),
        .o_level (w_fifo_level)
    );

    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) r_state <= ST_IDLE;
        else             r_state <= w_state_nxt;
    end

    // Each EXEC cycle either moves one byte or terminates the command.
    always_comb begin
        w_state_nxt = r_state;
        w_push      = 1'b0;
        w_pop       = 1'b0;
        w_flush     = 1'b0;
        w_set_err   = 1'b0;
        w_push_fin  = 1'b0;
        case (r_state)
            ST_IDLE:    if (w_detect) w_state_nxt = ST_CAPTURE;
            ST_CAPTURE: w_state_nxt = ST_EXEC;
            ST_EXEC: begin
                case (r_cmd)
                    CMD_PUSH: begin
                        if (r_idx == r_count) begin
                            w_push_fin  = 1'b1;
                            w_state_nxt = ST_DONE;
                        end else if (w_fifo_full) begin
                            w_push_fin  = 1'b1;
                            w_set_err   = 1'b1;
                            w_state_nxt = ST_DONE;
                        end else begin
                            w_push = 1'b1;
                        end
                    end
                    CMD_POP: begin
                        if (r_idx == r_count) begin
                            w_state_nxt = ST_DONE;
                        end else if (w_fifo_empty) begin
                            w_set_err   = 1'b1;
                            w_state_nxt = ST_DONE;
                        end else begin
                            w_pop = 1'b1;
                        end
                    end
                    CMD_FLUSH: begin
                        w_flush     = 1'b1;
                        w_state_nxt = ST_DONE;
                    end
                    default: w_state_nxt = ST_DONE;
                endcase
            end
            ST_DONE:    w_state_nxt = ST_IDLE;
            default:    w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            r_cmd      <= CMD_STATUS;
            r_last_req <= 1'b0;
            r_ack      <= 1'b0;
            r_busy     <= 1'b0;
            r_err      <= 1'b0;
            r_count    <= 4'd0;
            r_idx      <= 4'd0;
            for (int k = 0; k < 8; k++) begin
                r_cmd_data[k] <= 8'd0;
                r_rsp_data[k] <= 8'd0;
            end
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_detect) begin
                        r_cmd      <= cmd_e'(cmd_ctrl[c_ctrl_cmd_msb:c_ctrl_cmd_lsb]);
                        r_count    <= w_cnt_clamped;
                        r_last_req <= w_req;
                        r_busy     <= 1'b1;
                        for (int k = 0; k < 8; k++) r_cmd_data[k] <= w_cmd_data[k];
                    end
                end
                ST_CAPTURE: begin
                    r_idx <= 4'd0;
`ifndef PIO_MBOX_STICKY_ERR_EN
                    r_err <= 1'b0;
`endif
                    if (r_cmd == CMD_POP) begin
                        for (int k = 0; k < 8; k++) r_rsp_data[k] <= 8'd0;
                    end
                end
                ST_EXEC: begin
                    if (w_push) r_idx <= r_idx + 4'd1;
                    if (w_pop) begin
                        r_rsp_data[r_idx[2:0]] <= w_fifo_rdata;
                        r_idx                  <= r_idx + 4'd1;
                    end
                    if (w_push_fin) r_rsp_data[0] <= {4'd0, r_idx};
`ifdef PIO_MBOX_STICKY_ERR_EN
                    if (w_flush) r_err <= 1'b0;
`endif
                    if (w_set_err) r_err <= 1'b1;
                end
                ST_DONE: begin
                    r_ack  <= ~r_ack;
                    r_busy <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        rsp_stat                                = 8'd0;
        rsp_stat[c_stat_ack_bit]                = r_ack;
        rsp_stat[c_stat_busy_bit]               = r_busy;
        rsp_stat[c_stat_err_bit]                = r_err;
        rsp_stat[c_stat_lvl_msb:c_stat_lvl_lsb] = w_fifo_level;
    end

    assign rsp_data0 = r_rsp_data[0];
    assign rsp_data1 = r_rsp_data[1];
    assign rsp_data2 = r_rsp_data[2];
    assign rsp_data3 = r_rsp_data[3];
    assign rsp_data4 = r_rsp_data[4];
    assign rsp_data5 = r_rsp_data[5];
    assign rsp_data6 = r_rsp_data[6];
    assign rsp_data7 = r_rsp_data[7];

endmodule : pio_mailbox_responder

`default_nettype wire

// File: tb/tb_pio_mailbox_responder.sv
// ============================================================================
// Module : tb_pio_mailbox_responder
// Desc   : Directed self-checking bench for pio_mailbox_responder (DEPTH=16).
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_pio_mailbox_responder;

`ifdef PIO_MBOX_STICKY_ERR_EN
    localparam logic [7:0] c_sticky_err = 8'h04;
`else
    localparam logic [7:0] c_sticky_err = 8'h00;
`endif

    localparam logic [1:0] c_status = 2'b00;
    localparam logic [1:0] c_push   = 2'b01;
    localparam logic [1:0] c_pop    = 2'b10;
    localparam logic [1:0] c_flush  = 2'b11;

    logic       clk_clk = 1'b0;
    logic       reset_reset;
    logic [7:0] cmd_ctrl;
    logic [7:0] cmd_data0, cmd_data1, cmd_data2, cmd_data3;
    logic [7:0] cmd_data4, cmd_data5, cmd_data6, cmd_data7;
    logic [7:0] rsp_stat;
    logic [7:0] rsp_data0, rsp_data1, rsp_data2, rsp_data3;
    logic [7:0] rsp_data4, rsp_data5, rsp_data6, rsp_data7;
    logic [63:0] w_rsp;

    int   n_cmp = 0;
    int   n_bad = 0;
    logic r_req = 1'b0;
    int   lat;

    always #5 clk_clk = ~clk_clk;

    assign w_rsp = {rsp_data7, rsp_data6, rsp_data5, rsp_data4,
                    rsp_data3, rsp_data2, rsp_data1, rsp_data0};

    pio_mailbox_responder #(.DEPTH(16)) dut (
        .clk_clk     (clk_clk),
        .reset_reset (reset_reset),
        .cmd_ctrl    (cmd_ctrl),
        .cmd_data0   (cmd_data0),
        .cmd_data1   (cmd_data1),
        .cmd_data2   (cmd_data2),
        .cmd_data3   (cmd_data3),
        .cmd_data4   (cmd_data4),
        .cmd_data5   (cmd_data5),
        .cmd_data6   (cmd_data6),
        .cmd_data7   (cmd_data7),
        .rsp_stat    (rsp_stat),
        .rsp_data0   (rsp_data0),
        .rsp_data1   (rsp_data1),
        .rsp_data2   (rsp_data2),
        .rsp_data3   (rsp_data3),
        .rsp_data4   (rsp_data4),
        .rsp_data5   (rsp_data5),
        .rsp_data6   (rsp_data6),
        .rsp_data7   (rsp_data7)
    );

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic [1:0] cmd, input logic [3:0] cnt, input logic [63:0] data);
        @(negedge clk_clk);
        r_req    = ~r_req;
        cmd_ctrl = {1'b0, cnt, cmd, r_req};
        {cmd_data7, cmd_data6, cmd_data5, cmd_data4,
         cmd_data3, cmd_data2, cmd_data1, cmd_data0} = data;
    endtask

    // lat counts clock edges from the first edge after the call; -1 on timeout
    task automatic wait_ack(output int cycles);
        int i;
        cycles = -1;
        i      = 0;
        while (cycles < 0 && i < 40) begin
            @(posedge clk_clk);
            @(negedge clk_clk);
            if (rsp_stat[0] == r_req) cycles = i;
            i++;
        end
    endtask

    task automatic run_cmd(input string tag, input logic [1:0] cmd, input logic [3:0] cnt,
                           input logic [63:0] data, input int exp_lat,
                           input logic [7:0] exp_stat, input logic [63:0] exp_rsp);
        int l;
        issue(cmd, cnt, data);
        wait_ack(l);
        check_eq({tag, "_lat"},  64'(l), 64'(exp_lat));
        check_eq({tag, "_stat"}, 64'(rsp_stat), 64'(exp_stat));
        check_eq({tag, "_rsp"},  w_rsp, exp_rsp);
    endtask

    initial begin
        reset_reset = 1'b1;
        cmd_ctrl    = 8'h00;
        {cmd_data7, cmd_data6, cmd_data5, cmd_data4,
         cmd_data3, cmd_data2, cmd_data1, cmd_data0} = 64'h0;
        repeat (2) @(negedge clk_clk);
        check_eq("rst_stat", 64'(rsp_stat), 64'h00);
        check_eq("rst_rsp",  w_rsp, 64'h0);
        reset_reset = 1'b0;
        @(negedge clk_clk);
        check_eq("idle_stat", 64'(rsp_stat), 64'h00);

        run_cmd("status", c_status, 4'd0, 64'h0, 3, 8'h01, 64'h0);
        run_cmd("push3",  c_push,   4'd3, 64'h332211, 6, 8'h18, 64'h3);
        run_cmd("pop5",   c_pop,    4'd5, 64'h0, 6, 8'h05, 64'h332211);
        run_cmd("push8a", c_push,   4'd8, 64'h0807060504030201, 11,
                8'h40 | c_sticky_err, 64'h332208);
        run_cmd("push8b", c_push,   4'd8, 64'h100F0E0D0C0B0A09, 11,
                8'h81 | c_sticky_err, 64'h332208);
        run_cmd("push_full", c_push, 4'd4, 64'hDEADBEEF, 3, 8'h84, 64'h332200);
        run_cmd("pop2",   c_pop,    4'd2, 64'h0, 5, 8'h71 | c_sticky_err, 64'h0201);
        run_cmd("flush",  c_flush,  4'd0, 64'h0, 3, 8'h00, 64'h0201);
        run_cmd("clamp",  c_push,   4'd15, 64'hA8A7A6A5A4A3A2A1, 11, 8'h41, 64'h0208);

        // Reset in the middle of a PUSH, with a pending STATUS request at release
        issue(c_push, 4'd4, 64'h44332211);
        repeat (3) @(posedge clk_clk);
        @(negedge clk_clk);
        check_eq("mid_stat", 64'(rsp_stat), 64'h4B);
        #2 reset_reset = 1'b1;
        #1;
        check_eq("arst_stat", 64'(rsp_stat), 64'h00);
        check_eq("arst_rsp",  w_rsp, 64'h0);
        @(negedge clk_clk);
        r_req       = 1'b1;
        cmd_ctrl    = {1'b0, 4'd0, c_status, 1'b1};
        reset_reset = 1'b0;
        wait_ack(lat);
        check_eq("post_rst_lat",  64'(lat), 64'd3);
        check_eq("post_rst_stat", 64'(rsp_stat), 64'h01);

        // Double toggle while busy is lost
        issue(c_push, 4'd2, 64'h5A4B);
        @(negedge clk_clk);
        cmd_ctrl[0] = ~r_req;
        @(negedge clk_clk);
        cmd_ctrl[0] = r_req;
        wait_ack(lat);
        check_eq("dbl_lat", 64'(lat), 64'd3);
        repeat (10) @(negedge clk_clk);
        check_eq("dbl_stat", 64'(rsp_stat), 64'h10);
        check_eq("dbl_rsp",  w_rsp, 64'h2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_pio_mailbox_responder

`default_nettype wire

// File: doc/pio_mailbox_responder.md
PIO_MAILBOX_RESPONDER -- requirements
Module: pio_mailbox_responder

Interface
REQ-001 The block SHALL have parameter DEPTH, default 16, meaning byte-FIFO capacity; legal values are powers of two from 2 to 16.
REQ-002 The block SHALL have port clk_clk, input, 1 bit: the single clock, shared with the soft-processor system.
REQ-003 The block SHALL have port reset_reset, input, 1 bit: asynchronous, active-high reset.
REQ-004 The block SHALL have port cmd_ctrl, input, 8 bits: CPU control byte; bit0 req toggle, bits[2:1] cmd, bits[6:3] count, bit7 reserved.
REQ-005 The block SHALL have ports cmd_data0..cmd_data7, input, 8 bits each: CPU payload bytes.
REQ-006 The block SHALL have port rsp_stat, output, 8 bits: bit0 ack toggle, bit1 busy, bit2 error, bits[7:3] FIFO level.
REQ-007 The block SHALL have ports rsp_data0..rsp_data7, output, 8 bits each: response bytes.

Function
REQ-008 A new request SHALL be detected when the cmd_ctrl[0] level differs from the internal last_req register while the FSM is IDLE.
REQ-009 Commands SHALL be: 00 STATUS, 01 PUSH, 10 POP, 11 FLUSH.
REQ-010 Count values above 8 SHALL be clamped to 8; count 0 SHALL transfer nothing but still complete and acknowledge.
REQ-011 The FSM SHALL have states IDLE, CAPTURE, EXEC and DONE.
REQ-012 In the detect cycle, IDLE SHALL go to CAPTURE, and the FSM SHALL latch cmd, count and all eight cmd_data bytes, copy cmd_ctrl[0] into last_req, and set busy.
REQ-013 CAPTURE SHALL go to EXEC, clear the error flag, and clear rsp_data0..7 to 0 for POP only.
REQ-014 EXEC SHALL move at most one byte per cycle, byte index i from 0 to count-1, then go to DONE.
REQ-015 PUSH SHALL write cmd_data[i] into the FIFO; if the FIFO is full, the FSM SHALL set error and stop early.
REQ-016 On completion of a PUSH, rsp_data0 SHALL hold the number of bytes accepted and rsp_data1..7 SHALL be unchanged.
REQ-017 POP SHALL place the FIFO head in rsp_data[i]; if the FIFO is empty, the FSM SHALL set error and stop early, and rsp_data bytes from index i onward SHALL remain 0.
REQ-018 FLUSH SHALL empty the FIFO in one EXEC cycle; STATUS SHALL spend one EXEC cycle and change no data.
REQ-019 DONE SHALL invert the ack bit, clear busy and return to IDLE; ack SHALL equal req at rest.
REQ-020 Latency from the detect cycle to the ack flip SHALL be 3+n cycles for PUSH and POP, where n is the number of bytes moved, and 3 cycles for STATUS and FLUSH.
REQ-021 A req toggle while busy SHALL NOT be serviced immediately; if the req level still differs from last_req at IDLE it SHALL be serviced then, and a double toggle during busy SHALL be lost.
REQ-022 rsp_stat[7:3] SHALL always reflect the current FIFO level, 0..DEPTH, updated in the same cycle as each push or pop.

Reset
REQ-023 Reset SHALL, asynchronously: empty the FIFO, set the FSM to IDLE, clear last_req, ack, busy and error to 0, and clear rsp_stat and rsp_data0..7 to 0.
REQ-024 Reset asserted mid-EXEC SHALL abort the command with no further FIFO change after release.
REQ-025 After reset release, a cmd_ctrl[0] value of 1 SHALL be treated as a pending request.

Configuration
REQ-026 When PIO_MBOX_STICKY_ERR_EN is defined, the error bit SHALL be sticky: CAPTURE SHALL not clear it, and only FLUSH or reset SHALL clear it.
REQ-027 When PIO_MBOX_STICKY_ERR_EN is not defined, the error bit SHALL reflect the last command only.

Structure
REQ-028 Package pio_mbox_pkg SHALL hold the cmd enum, the FSM state enum, and the rsp_stat and cmd_ctrl bit-position constants.
REQ-029 Sub-module mbox_byte_fifo SHALL implement the synchronous single-clock FIFO with push, pop, flush, full, empty and level.

Verification
REQ-030 Scenario: after reset, rsp_stat=0x00 and all rsp_data=0; toggle req with STATUS -> ack flips after 3 cycles, level=0, error=0.
REQ-031 Scenario: PUSH count=3 with bytes 0x11,0x22,0x33 -> ack after 6 cycles, rsp_data0=3, level=3.
REQ-032 Scenario: POP count=5 with level=3 -> rsp_data0..2=0x11,0x22,0x33, rsp_data3..4=0, error=1, level=0.
REQ-033 Scenario: PUSH count=8 twice, then PUSH count=4 with DEPTH=16 -> third response rsp_data0=0, error=1, level=16.
REQ-034 Scenario: count=15 PUSH -> clamped to 8; then FLUSH -> level=0; with the macro defined, error clears only on FLUSH.
REQ-035 Scenario: reset pulse mid-PUSH, and double req toggle while busy -> FSM IDLE, level=0, and the lost request is not serviced.
